// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, HALT opcode, PC step.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    BLOCKED = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  localparam logic [3:0]  HALT_OP_DEFAULT = 4'hF;
  localparam logic [15:0] PC_STEP         = 16'h0002;

endpackage

// File: rtl/fetch_unit_cla.sv
// 16-bit carry-lookahead adder/subtractor (mode 0 = a+b, mode 1 = a-b), 4-bit groups.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  output logic [15:0] sum
);

  logic [15:0] bx, g, p, c;
  logic [2:0]  grp_g, grp_p;
  logic [3:0]  grp_c;

  always_comb begin
    bx = b ^ {16{mode}};
    g  = a & bx;
    p  = a ^ bx;
    for (int unsigned k = 0; k < 3; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
    grp_c[0] = mode;
    for (int unsigned k = 1; k < 4; k++)
      grp_c[k] = grp_g[k-1] | (grp_p[k-1] & grp_c[k-1]);
    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int unsigned j = 1; j < 4; j++)
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
    end
    sum = p ^ c;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM, IF/ID register with one-entry skid buffer.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc, pc_plus2, squash_addr, redirect_pc;
  logic         squash;
  logic         skid_valid;
  logic [15:0]  skid_instr, skid_pc;
  logic         deliver, to_ifid, is_halt;

  CLA_16bit u_pc_adder (
    .a    (pc),
    .b    (PC_STEP),
    .mode (1'b0),
    .sum  (pc_plus2)
  );

  assign redirect_pc = branch_pc & 16'hFFFE;
  assign deliver     = (state == REQ) && imem_ready && !squash;
  assign to_ifid     = !stall || !ifid_valid;
  assign is_halt     = (imem_data[15:12] == HALT_OP);

  // While a squashed response is outstanding the bus keeps the old address; pc already holds the target.
  assign imem_addr = squash ? squash_addr : pc;
  assign imem_req  = (state == REQ);
  assign halted    = (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      squash_addr <= '0;
      ifid_valid  <= 1'b0;
      ifid_instr  <= '0;
      ifid_pc     <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
    end else if (branch_taken) begin
      state      <= REQ;
      pc         <= redirect_pc;
      ifid_valid <= 1'b0;
      skid_valid <= 1'b0;
      squash     <= (state == REQ) && !imem_ready;
      if ((state == REQ) && !imem_ready && !squash)
        squash_addr <= pc;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) begin
            if (squash)        squash <= 1'b0;
            else if (is_halt)  state  <= HALTED;
            else if (!to_ifid) state  <= BLOCKED;
            else               pc     <= pc_plus2;
          end
        end
        BLOCKED: begin
          if (!stall) begin
            state <= REQ;
            pc    <= pc_plus2;
          end
        end
        default: ;
      endcase

      if (deliver && to_ifid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= imem_data;
        ifid_pc    <= pc;
      end else if (deliver) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_data;
        skid_pc    <= pc;
      end else if (!stall && skid_valid) begin
        ifid_valid <= 1'b1;
        ifid_instr <= skid_instr;
        ifid_pc    <= skid_pc;
        skid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed protocol steps, then random traffic against an in-order program-stream model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
  logic [15:0] branch_pc = '0, imem_data = '0;
  logic        imem_req, ifid_valid, halted;
  logic [15:0] imem_addr, ifid_instr, ifid_pc;

  logic        w_stall = 1'b0, w_branch_taken = 1'b0, w_imem_ready = 1'b1;
  logic [15:0] w_branch_pc = '0, w_imem_data = '0;
  logic        w_imem_req, w_ifid_valid, w_halted;
  logic [15:0] w_imem_addr, w_ifid_instr, w_ifid_pc;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] halt_addr = 16'h0001;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(w_stall), .branch_taken(w_branch_taken),
    .branch_pc(w_branch_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ready(w_imem_ready), .imem_data(w_imem_data), .ifid_valid(w_ifid_valid),
    .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc), .halted(w_halted)
  );

  // Program image: word at address 2i is 16'h1000+i, except an optional HALT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'hF000;
    return 16'h1000 + {1'b0, a[15:1]};
  endfunction

  task automatic refresh();
    imem_data   = mem_word(imem_addr);
    w_imem_data = mem_word(w_imem_addr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [15:0] instr);
    chk1({tag, "_valid"}, ifid_valid, 1'b1);
    chk16({tag, "_pc"}, ifid_pc, pc);
    chk16({tag, "_instr"}, ifid_instr, instr);
  endtask

  initial begin
    logic [15:0] a, exp_pc, pend_addr, bpc;
    logic        st, br, rdy, pend;
    int          idle, consumed;

    // Reset state
    refresh();
    repeat (3) step();
    chk1("rst_req", imem_req, 1'b0);
    chk16("rst_addr", imem_addr, 16'h0000);
    chk1("rst_valid", ifid_valid, 1'b0);
    chk16("rst_instr", ifid_instr, 16'h0000);
    chk16("rst_pc", ifid_pc, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    chk1("wrap_rst_req", w_imem_req, 1'b0);
    chk16("wrap_rst_addr", w_imem_addr, 16'hFFFE);
    chk1("wrap_rst_halted", w_halted, 1'b0);

    // Release, zero-wait streaming
    rst_n = 1'b1;
    chk1("cyc1_req", imem_req, 1'b0);
    step();
    chk1("cyc2_req", imem_req, 1'b1);
    chk16("cyc2_addr", imem_addr, 16'h0000);
    chk1("wrap_cyc2_req", w_imem_req, 1'b1);
    chk16("wrap_cyc2_addr", w_imem_addr, 16'hFFFE);
    step();
    chk_ifid("stream0", 16'h0000, 16'h1000);
    chk1("wrap_first_valid", w_ifid_valid, 1'b1);
    chk16("wrap_first_pc", w_ifid_pc, 16'hFFFE);
    chk16("wrap_first_instr", w_ifid_instr, 16'h8FFF);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_ifid("stream", 16'(2 * k), 16'(16'h1000 + k));
      if (k == 1) begin
        chk16("wrap_second_pc", w_ifid_pc, 16'h0000);
        chk16("wrap_second_instr", w_ifid_instr, 16'h1000);
      end
    end
    chk16("stream_addr", imem_addr, 16'h000A);

    // Stall for three cycles: IF/ID holds, next word parks in skid, requests stop
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("stall_hold", 16'h0008, 16'h1004);
      chk1("stall_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    step();
    chk_ifid("skid_drain", 16'h000A, 16'h1005);
    chk1("resume_req", imem_req, 1'b1);
    chk16("resume_addr", imem_addr, 16'h000C);
    step();
    chk_ifid("resume", 16'h000C, 16'h1006);

    // One wait state per access
    a = 16'h000E;
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'b0;
      step();
      chk1("wait_bubble", ifid_valid, 1'b0);
      chk16("wait_addr_hold", imem_addr, a);
      imem_ready = 1'b1;
      step();
      chk_ifid("wait_deliver", a, mem_word(a));
      a = a + 16'h2;
    end

    // Redirect while a request is pending: old response is squashed
    branch_taken = 1'b1;
    branch_pc    = 16'h0041;
    imem_ready   = 1'b0;
    step();
    branch_taken = 1'b0;
    chk1("br_flush", ifid_valid, 1'b0);
    chk1("br_req", imem_req, 1'b1);
    chk16("br_old_addr", imem_addr, 16'h0014);
    step();
    chk16("br_old_addr2", imem_addr, 16'h0014);
    imem_ready = 1'b1;
    step();
    chk1("br_squashed", ifid_valid, 1'b0);
    chk16("br_target_addr", imem_addr, 16'h0040);
    step();
    chk_ifid("br_target", 16'h0040, 16'h1020);

    // HALT at 0x0006, then wake by redirect
    halt_addr = 16'h0006;
    refresh();
    branch_taken = 1'b1;
    branch_pc    = 16'h0000;
    step();
    branch_taken = 1'b0;
    chk1("hrst_flush", ifid_valid, 1'b0);
    chk16("hrst_addr", imem_addr, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_ifid("hstream", 16'(2 * k), 16'(16'h1000 + k));
    end
    step();
    chk_ifid("halt_word", 16'h0006, 16'hF000);
    chk1("halt_flag", halted, 1'b1);
    chk1("halt_req", imem_req, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk1("halt_stay", halted, 1'b1);
      chk1("halt_req_stay", imem_req, 1'b0);
    end
    branch_taken = 1'b1;
    branch_pc    = 16'h0100;
    step();
    branch_taken = 1'b0;
    chk1("wake_halted", halted, 1'b0);
    chk1("wake_req", imem_req, 1'b1);
    chk16("wake_addr", imem_addr, 16'h0100);
    step();
    chk_ifid("wake_fetch", 16'h0100, 16'h1080);
    halt_addr = 16'h0001;
    refresh();

    // Random traffic: decode must consume the program in order from the latest redirect target
    exp_pc   = '0;
    pend     = 1'b0;
    pend_addr = '0;
    idle     = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = (cyc == 0) || ($urandom_range(0, 19) == 0);
      bpc = 16'($urandom);
      rdy = imem_req && ($urandom_range(0, 2) != 0);
      if (pend) chk16("rnd_addr_hold", imem_addr, pend_addr);
      if (ifid_valid && !st && !br) begin
        chk16("rnd_pc", ifid_pc, exp_pc);
        chk16("rnd_instr", ifid_instr, mem_word(exp_pc));
        exp_pc   = exp_pc + 16'h2;
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 80) begin
        chk16("rnd_progress", 16'(idle), 16'h0000);
        break;
      end
      stall        = st;
      branch_taken = br;
      branch_pc    = bpc;
      imem_ready   = rdy;
      if (br) exp_pc = bpc & 16'hFFFE;
      pend      = imem_req && !rdy;
      pend_addr = imem_addr;
      step();
    end
    chk1("rnd_volume", consumed >= 150, 1'b1);
    chk1("rnd_not_halted", halted, 1'b0);

    // Asynchronous reset in the middle of a wait
    stall        = 1'b0;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    refresh();
    chk1("arst_req", imem_req, 1'b0);
    chk16("arst_addr", imem_addr, 16'h0000);
    chk1("arst_valid", ifid_valid, 1'b0);
    chk16("arst_instr", ifid_instr, 16'h0000);
    chk16("arst_pc", ifid_pc, 16'h0000);
    chk1("arst_halted", halted, 1'b0);
    imem_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk1("arst_cyc1_req", imem_req, 1'b0);
    step();
    chk1("arst_cyc2_req", imem_req, 1'b1);
    chk16("arst_cyc2_addr", imem_addr, 16'h0000);
    step();
    chk_ifid("arst_refetch", 16'h0000, 16'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
